// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Ops are latched on accept; the result returns with a valid/ready handshake.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ALU_ADD
`define ALU_ADD     4'h0
`define ALU_SUB     4'h1
`define ALU_AND     4'h2
`define ALU_OR      4'h3
`define ALU_XOR     4'h4
`define ALU_SLL     4'h5
`define ALU_SRL     4'h6
`define ALU_SRA     4'h7
`define ALU_SLT     4'h8
`define ALU_SLTU    4'h9
`define ALU_NOP     4'hE
`define ALU_INVALID 4'hF
`endif

module alu_arbiter #(
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_sel,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_sel,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_err
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  state_t                st_eff;
  logic                  prio;
  logic                  prio_eff;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [3:0]            op_sel;
  logic                  op_id;
  logic                  accept_en;
  logic                  gnt0;
  logic                  gnt1;
  logic                  accept;
  logic                  sel_ok;

  // While reset is held the handshake behaves as if already in IDLE
  assign st_eff    = rst_n ? state : IDLE;
  assign prio_eff  = rst_n & prio;

  assign accept_en = (st_eff == IDLE) |
                     ((st_eff == RESP) & rsp_ready);

  assign gnt1 = req1_valid & (~req0_valid | prio_eff);
  assign gnt0 = req0_valid & ~gnt1;

  assign req0_ready = accept_en & gnt0;
  assign req1_ready = accept_en & gnt1;
  assign accept     = req0_ready | req1_ready;

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_sel   = op_sel;
  assign rsp_valid = (state == RESP);

  always_comb begin
    sel_ok = 1'b0;
    case (op_sel)
      `ALU_ADD, `ALU_SUB, `ALU_AND,
      `ALU_OR, `ALU_XOR, `ALU_SLL,
      `ALU_SRL, `ALU_SRA, `ALU_SLT,
      `ALU_SLTU, `ALU_NOP: sel_ok = 1'b1;
      default:             sel_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready)
          state_nxt = accept ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_sel   <= `ALU_NOP;
      op_id    <= 1'b0;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= req1_ready ? req1_a : req0_a;
        op_b   <= req1_ready ? req1_b : req0_b;
        op_sel <= req1_ready ? req1_sel : req0_sel;
        op_id  <= req1_ready;
        prio   <= ~req1_ready;
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        rsp_id   <= op_id;
        rsp_err  <= ~sel_ok;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural shared ALU.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLT = 4'h8;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_INV = 4'hF;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_err;

  int   n_vec;
  int   n_err;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(
    logic [31:0] a, logic [31:0] b, logic [3:0] s);
    case (s)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return a << b[4:0];
      4'h6: return a >> b[4:0];
      4'h7: return $signed(a) >>> b[4:0];
      4'h8: return {31'b0, $signed(a) < $signed(b)};
      4'h9: return {31'b0, a < b};
      4'hE: return 32'h0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic logic err_ref(logic [3:0] s);
    return !(s <= 4'h9 || s == 4'hE);
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_sel);

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  // Samples the settled cycle: pops on a completed response,
  // pushes the expected result of any accept.
  task automatic observe(output bit got, output bit under,
                         output rsp_t act, output rsp_t ex);
    got = 0; under = 0; act = '0; ex = '0;
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        got = 1;
        act = '{rsp_id, rsp_data, rsp_err};
        if (exp_q.size() == 0) under = 1;
        else ex = exp_q.pop_front();
      end
      if (req0_valid && req0_ready)
        exp_q.push_back('{1'b0, alu_ref(req0_a, req0_b, req0_sel),
                          err_ref(req0_sel)});
      if (req1_valid && req1_ready)
        exp_q.push_back('{1'b1, alu_ref(req1_a, req1_b, req1_sel),
                          err_ref(req1_sel)});
    end
  endtask

  task automatic do_reset();
    bit g, u; rsp_t a, e;
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    observe(g, u, a, e);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    bit g, u; rsp_t a, e;
    rst_n = 0; req0_valid = 0; req1_valid = 1;
    req1_a = 32'd9; req1_b = 32'd9; req1_sel = OP_ADD;
    rsp_ready = 1;
    repeat (2) begin observe(g, u, a, e); @(negedge clk); end
    observe(g, u, a, e);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_vec++; if ({rsp_data, rsp_id, rsp_err} !== 34'h0) begin n_err++;
      $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_data, rsp_id, rsp_err); end
    n_vec++; if (alu_sel !== OP_NOP || alu_a !== 0 || alu_b !== 0) begin n_err++;
      $display("FAIL reset_op got sel=%h a=%h b=%h want NOP/0/0", alu_sel, alu_a, alu_b); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++;
      $display("FAIL reset_ready got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk);
    rst_n = 1; req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (rsp_valid !== 1'b0 || alu_sel !== OP_NOP) begin n_err++;
      $display("FAIL reset_no_accept got valid=%b sel=%h want 0/NOP", rsp_valid, alu_sel); end
    @(negedge clk);
  endtask

  task automatic test_single();
    bit g, u; rsp_t a, e;
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_sel = OP_ADD;
    rsp_ready = 1;
    observe(g, u, a, e);
    n_vec++; if (req0_ready !== 1'b1) begin n_err++;
      $display("FAIL single_ready got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    observe(g, u, a, e);
    n_vec++; if (rsp_valid !== 1'b0 || alu_a !== 5 || alu_b !== 7 || alu_sel !== OP_ADD) begin
      n_err++; $display("FAIL single_exec got v=%b a=%h b=%h s=%h want 0/5/7/ADD",
                        rsp_valid, alu_a, alu_b, alu_sel); end
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b0, 32'd12, 1'b0}) begin n_err++;
      $display("FAIL single_rsp got g=%b %h want id0 data 12 err0 (sb %h)", g, a, e); end
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++;
      $display("FAIL single_idle got %b want 0", rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit g, u; rsp_t a, e, k;
    do_reset();
    req0_valid = 1; req0_a = 3; req0_b = 5; req0_sel = OP_SUB;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h3C; req1_sel = OP_AND;
    for (int c = 0; c < 10; c++) begin
      observe(g, u, a, e);
      n_vec++;
      if (req0_ready !== (c % 4 == 0) || req1_ready !== (c % 4 == 2) ||
          rsp_valid !== (c >= 2 && c % 2 == 0)) begin
        n_err++; $display("FAIL contend_c%0d got r0=%b r1=%b v=%b", c,
                          req0_ready, req1_ready, rsp_valid); end
      if (g) begin
        k = (c % 4 == 2) ? rsp_t'{1'b0, 32'hFFFFFFFE, 1'b0}
                         : rsp_t'{1'b1, 32'h30, 1'b0};
        n_vec++; if (u || a !== e || a !== k) begin n_err++;
          $display("FAIL contend_rsp_c%0d got %h want %h", c, a, k); end
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    repeat (3) begin
      observe(g, u, a, e);
      if (g) begin n_vec++; if (u || a !== e) begin n_err++;
        $display("FAIL contend_drain got %h want %h", a, e); end end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit g, u; rsp_t a, e;
    do_reset();
    req0_valid = 1; req0_a = 32'h0F; req0_b = 32'hF0; req0_sel = OP_OR;
    req1_valid = 1; req1_a = 32'hAA; req1_b = 32'h0F; req1_sel = OP_XOR;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    @(negedge clk);
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      observe(g, u, a, e);
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hFF || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++;
        $display("FAIL hold_%0d got v=%b d=%h id=%b r=%b%b want 1/FF/0/00",
                 k, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready); end
      @(negedge clk);
    end
    rsp_ready = 1;
    observe(g, u, a, e);
    n_vec++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_err++;
      $display("FAIL hold_release_ready got %b%b want 01", req0_ready, req1_ready); end
    n_vec++; if (!g || u || a !== e || a.data !== 32'hFF) begin n_err++;
      $display("FAIL hold_rsp got %h want %h", a, e); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b1, 32'hA5, 1'b0}) begin n_err++;
      $display("FAIL hold_rsp2 got %h want id1 A5 (sb %h)", a, e); end
    @(negedge clk);
  endtask

  task automatic test_invalid();
    bit g, u; rsp_t a, e;
    do_reset();
    req1_valid = 1; req1_a = 1; req1_b = 2; req1_sel = OP_INV;
    observe(g, u, a, e);
    n_vec++; if (req1_ready !== 1'b1) begin n_err++;
      $display("FAIL inv_ready got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b1, 32'hDEADBEEF, 1'b1}) begin
      n_err++; $display("FAIL inv_rsp got %h want id1 DEADBEEF err1", a); end
    @(negedge clk);
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_sel = 4'hB;
    observe(g, u, a, e);
    @(negedge clk);
    req0_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b0, 32'hDEADBEEF, 1'b1}) begin
      n_err++; $display("FAIL unlisted_rsp got %h want id0 DEADBEEF err1", a); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    bit g, u; rsp_t a, e;
    do_reset();
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_sel = OP_ADD;
    req1_valid = 1; req1_a = 2; req1_b = 2; req1_sel = OP_ADD;
    observe(g, u, a, e);
    @(negedge clk);
    rst_n = 0; req0_valid = 0; req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    rst_n = 1;
    observe(g, u, a, e);
    n_vec++; if (rsp_valid !== 1'b0 || alu_sel !== OP_NOP || alu_a !== 0) begin n_err++;
      $display("FAIL midrst got v=%b sel=%h a=%h want 0/NOP/0", rsp_valid, alu_sel, alu_a); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      observe(g, u, a, e);
      n_vec++; if (rsp_valid !== 1'b0 || g) begin n_err++;
        $display("FAIL midrst_stale_%0d got v=%b want 0", k, rsp_valid); end
    end
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    observe(g, u, a, e);
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++;
      $display("FAIL midrst_prio got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b0, 32'd2, 1'b0}) begin n_err++;
      $display("FAIL midrst_rsp got %h want id0 data 2", a); end
    @(negedge clk);
  endtask

  task automatic test_req1_alone();
    bit g, u; rsp_t a, e;
    do_reset();
    req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 1; req1_sel = OP_SLT;
    observe(g, u, a, e);
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++;
      $display("FAIL alone_ready got %b%b want 01", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1; req0_a = 2; req0_b = 3; req0_sel = OP_ADD;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++;
      $display("FAIL alone_prio got %b%b want 10", req0_ready, req1_ready); end
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b1, 32'd1, 1'b0}) begin n_err++;
      $display("FAIL alone_rsp got %h want id1 data 1", a); end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    observe(g, u, a, e);
    @(negedge clk);
    observe(g, u, a, e);
    n_vec++; if (!g || u || a !== e || a !== rsp_t'{1'b0, 32'd5, 1'b0}) begin n_err++;
      $display("FAIL alone_rsp2 got %h want id0 data 5", a); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit g, u; rsp_t a, e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom_range(0, 15));
      req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 3) != 0);
      observe(g, u, a, e);
      if (req0_ready && req1_ready) begin n_vec++; n_err++;
        $display("FAIL rand_both_ready c%0d", c); end
      if (g) begin n_vec++; if (u || a !== e) begin n_err++;
        $display("FAIL rand_rsp c%0d got %h want %h", c, a, e); end end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    repeat (4) begin
      observe(g, u, a, e);
      if (g) begin n_vec++; if (u || a !== e) begin n_err++;
        $display("FAIL rand_drain got %h want %h", a, e); end end
      @(negedge clk);
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++;
      $display("FAIL rand_pending got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_invalid();
    test_reset_mid_exec();
    test_req1_alone();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
